// File: rtl/flash_resp_pkg.sv
// Shared constants for the NOR flash responder: command bytes, control-bus
// bit positions, status-register bits and FSM state encodings.
package flash_resp_pkg;

   localparam logic [7:0] CMD_READ_ARRAY   = 8'hFF;
   localparam logic [7:0] CMD_READ_STATUS  = 8'h70;
   localparam logic [7:0] CMD_CLEAR_STATUS = 8'h50;
   localparam logic [7:0] CMD_PROGRAM      = 8'h40;
   localparam logic [7:0] CMD_PROGRAM_ALT  = 8'h10;
   localparam logic [7:0] CMD_ERASE        = 8'h20;
   localparam logic [7:0] CMD_CONFIRM      = 8'hD0;
   localparam logic [7:0] CMD_READ_ID      = 8'h90;

   localparam int CTL_WE_N   = 0;
   localparam int CTL_OE_N   = 1;
   localparam int CTL_CE_N   = 2;
   localparam int CTL_RP_N   = 3;
   localparam int CTL_VPEN   = 4;
   localparam int CTL_BYTE_N = 5;

   localparam int SR_READY     = 7;
   localparam int SR_ERASE_ERR = 5;
   localparam int SR_PROG_ERR  = 4;
   localparam int SR_VPEN_LOW  = 3;

   localparam logic [7:0] SR_RESET     = 8'h80;
   localparam logic [7:0] SR_SEQ_ERR   = 8'h30;
   localparam logic [7:0] SR_CLEARABLE = 8'h38;

   typedef enum logic [2:0] {
      S_ARRAY       = 3'd0,
      S_STATUS      = 3'd1,
      S_PROG_SETUP  = 3'd2,
      S_ERASE_SETUP = 3'd3,
      S_PROG_BUSY   = 3'd4,
      S_ERASE_BUSY  = 3'd5,
      S_READ_ID     = 3'd6
   } flashState_e;

   localparam logic [2:0] ST_ARRAY       = S_ARRAY;
   localparam logic [2:0] ST_STATUS      = S_STATUS;
   localparam logic [2:0] ST_PROG_SETUP  = S_PROG_SETUP;
   localparam logic [2:0] ST_ERASE_SETUP = S_ERASE_SETUP;
   localparam logic [2:0] ST_PROG_BUSY   = S_PROG_BUSY;
   localparam logic [2:0] ST_ERASE_BUSY  = S_ERASE_BUSY;
   localparam logic [2:0] ST_READ_ID     = S_READ_ID;

endpackage

// File: rtl/flash_resp_mem.sv
// Word array behind the flash responder: registered read, one write port.
module flash_resp_mem #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] i_rdAddr,
   output logic [15:0]       o_rdData,
   input  logic              i_wrEn,
   input  logic [ADDR_W-1:0] i_wrAddr,
   input  logic [15:0]       i_wrData
);

   // Words are stored inverted so a zero-initialised array powers up reading
   // as erased flash (0xFFFF) without any load pass.
   logic [15:0] r_memInv [0:(1<<ADDR_W)-1];

   always_ff @(posedge clk) begin
      if (i_wrEn) begin
         r_memInv[i_wrAddr] <= ~i_wrData;
      end
      o_rdData <= ~r_memInv[i_rdAddr];
   end

endmodule

// File: rtl/flash_responder.sv
// Device-side model of a 16-bit Intel-style NOR flash on the parallel bus.
// Define FLASH_RESP_ID_EN to enable the 0x90 read-identifier mode.
module flash_responder
   import flash_resp_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int BLOCK_LOG2 = 6,
   parameter int PROG_CYC   = 8,
   parameter int ERASE_CYC  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [22:0] flash_addr,
   inout  wire  [15:0] flash_data,
   input  logic [7:0]  flash_ctl,
   output logic        busy_o,
   output logic [7:0]  sr_o
);

   localparam int          BLK_W      = ADDR_W - BLOCK_LOG2;
   localparam logic [15:0] WALK_LAST  = 16'((1 << BLOCK_LOG2) - 1);
   localparam logic [15:0] PROG_LOAD  = 16'(PROG_CYC - 1);
   localparam logic [15:0] ERASE_LOAD = 16'(ERASE_CYC - 1);

   logic              w_rstAll;
   logic              w_commit;
   logic              w_vpen;
   logic              w_drive;
   logic              w_memWe;
   logic              w_cmdClear;
   logic              w_unused;
   logic [7:0]        w_cmd;
   logic [7:0]        w_cmdSrSet;
   logic [2:0]        w_cmdState;
   logic [ADDR_W-1:0] w_rdAddr;
   logic [ADDR_W-1:0] w_wrAddr;
   logic [15:0]       w_wrData;
   logic [15:0]       w_memRd;
   logic [15:0]       w_word;
   logic [15:0]       w_busWord;

   logic              r_prevWeN;
   logic              r_prevCeN;
   logic              r_byteHi;
   logic              r_erHold;
   logic [2:0]        r_state;
   logic [7:0]        r_sr;
   logic [15:0]       r_count;
   logic [15:0]       r_wrData;
   logic [15:0]       r_opData;
   logic [ADDR_W-1:0] r_wrAddr;
   logic [ADDR_W-1:0] r_opAddr;
   logic [BLK_W-1:0]  r_blk;
`ifdef FLASH_RESP_ID_EN
   logic [ADDR_W-1:0] r_rdIdx;
`endif

   assign w_rstAll = ~rst | ~flash_ctl[CTL_RP_N];
   assign w_vpen   = flash_ctl[CTL_VPEN];
   assign w_cmd    = r_wrData[7:0];
   assign w_commit = ~r_prevWeN & ~r_prevCeN & flash_ctl[CTL_WE_N];
   assign w_unused = ^{flash_ctl[7:6], flash_addr[22:ADDR_W+1]};

   always_ff @(posedge clk) begin
      if (~flash_ctl[CTL_CE_N] & ~flash_ctl[CTL_WE_N]) begin
         r_wrAddr <= flash_addr[ADDR_W:1];
         r_wrData <= flash_data;
      end
      r_byteHi <= flash_addr[0];
`ifdef FLASH_RESP_ID_EN
      r_rdIdx  <= flash_addr[ADDR_W:1];
`endif
   end

   always_comb begin
      w_cmdState = r_state;
      w_cmdSrSet = 8'h00;
      w_cmdClear = 1'b0;
      case (w_cmd)
         CMD_READ_ARRAY:               w_cmdState = ST_ARRAY;
         CMD_READ_STATUS:              w_cmdState = ST_STATUS;
         CMD_CLEAR_STATUS:             w_cmdClear = 1'b1;
         CMD_PROGRAM, CMD_PROGRAM_ALT: w_cmdState = ST_PROG_SETUP;
         CMD_ERASE:                    w_cmdState = ST_ERASE_SETUP;
`ifdef FLASH_RESP_ID_EN
         CMD_READ_ID:                  w_cmdState = ST_READ_ID;
`endif
         default: begin
            w_cmdState = ST_STATUS;
            w_cmdSrSet = SR_SEQ_ERR;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_rstAll) begin
         r_state   <= ST_ARRAY;
         r_sr      <= SR_RESET;
         r_count   <= 16'h0000;
         r_erHold  <= 1'b0;
         r_prevWeN <= 1'b1;
         r_prevCeN <= 1'b1;
      end else begin
         r_prevWeN <= flash_ctl[CTL_WE_N];
         r_prevCeN <= flash_ctl[CTL_CE_N];
         case (r_state)
            ST_ARRAY, ST_STATUS, ST_READ_ID: begin
               if (w_commit) begin
                  r_state <= w_cmdState;
                  r_sr    <= w_cmdClear ? (r_sr & ~SR_CLEARABLE) : (r_sr | w_cmdSrSet);
               end
            end
            ST_PROG_SETUP: begin
               if (w_commit) begin
                  if (!w_vpen) begin
                     r_sr[SR_VPEN_LOW] <= 1'b1;
                     r_sr[SR_PROG_ERR] <= 1'b1;
                     r_state           <= ST_STATUS;
                  end else begin
                     r_opAddr       <= r_wrAddr;
                     r_opData       <= r_wrData;
                     r_count        <= PROG_LOAD;
                     r_sr[SR_READY] <= 1'b0;
                     r_state        <= ST_PROG_BUSY;
                  end
               end
            end
            ST_ERASE_SETUP: begin
               if (w_commit) begin
                  if (w_cmd != CMD_CONFIRM) begin
                     r_sr    <= r_sr | SR_SEQ_ERR;
                     r_state <= ST_STATUS;
                  end else if (!w_vpen) begin
                     r_sr[SR_VPEN_LOW]  <= 1'b1;
                     r_sr[SR_ERASE_ERR] <= 1'b1;
                     r_state            <= ST_STATUS;
                  end else begin
                     r_blk          <= r_wrAddr[ADDR_W-1:BLOCK_LOG2];
                     r_count        <= 16'h0000;
                     r_erHold       <= 1'b0;
                     r_sr[SR_READY] <= 1'b0;
                     r_state        <= ST_ERASE_BUSY;
                  end
               end
            end
            ST_PROG_BUSY: begin
               if (r_count == 16'h0000) begin
                  r_sr[SR_READY] <= 1'b1;
                  r_state        <= ST_STATUS;
               end else begin
                  r_count <= r_count - 16'h0001;
               end
            end
            ST_ERASE_BUSY: begin
               // The walk phase counts up through the block, the hold phase counts down.
               if (!r_erHold) begin
                  if (r_count == WALK_LAST) begin
                     r_erHold <= 1'b1;
                     r_count  <= ERASE_LOAD;
                  end else begin
                     r_count <= r_count + 16'h0001;
                  end
               end else if (r_count == 16'h0000) begin
                  r_sr[SR_READY] <= 1'b1;
                  r_state        <= ST_STATUS;
               end else begin
                  r_count <= r_count - 16'h0001;
               end
            end
            default: r_state <= ST_ARRAY;
         endcase
      end
   end

   // During a program the read port fetches the target word so it can be ANDed.
   always_comb begin
      case (r_state)
         ST_PROG_SETUP: w_rdAddr = r_wrAddr;
         ST_PROG_BUSY:  w_rdAddr = r_opAddr;
         default:       w_rdAddr = flash_addr[ADDR_W:1];
      endcase
   end

   assign w_memWe  = ~w_rstAll &
                     (((r_state == ST_PROG_BUSY) && (r_count == 16'h0000)) ||
                      ((r_state == ST_ERASE_BUSY) && !r_erHold));
   assign w_wrAddr = (r_state == ST_ERASE_BUSY) ? {r_blk, r_count[BLOCK_LOG2-1:0]} : r_opAddr;
   assign w_wrData = (r_state == ST_ERASE_BUSY) ? 16'hFFFF : (w_memRd & r_opData);

   flash_resp_mem #(.ADDR_W(ADDR_W)) u_mem (
      .clk      (clk),
      .i_rdAddr (w_rdAddr),
      .o_rdData (w_memRd),
      .i_wrEn   (w_memWe),
      .i_wrAddr (w_wrAddr),
      .i_wrData (w_wrData)
   );

   always_comb begin
      w_word = {8'h00, r_sr};
      if (r_state == ST_ARRAY) begin
         w_word = w_memRd;
      end
`ifdef FLASH_RESP_ID_EN
      else if (r_state == ST_READ_ID) begin
         if (r_rdIdx == ADDR_W'(0)) begin
            w_word = 16'h0089;
         end else if (r_rdIdx == ADDR_W'(1)) begin
            w_word = 16'h0018;
         end else begin
            w_word = 16'h0000;
         end
      end
`endif
      w_busWord = flash_ctl[CTL_BYTE_N] ? w_word
                : {8'h00, (r_byteHi ? w_word[15:8] : w_word[7:0])};
   end

   assign w_drive    = rst & ~flash_ctl[CTL_CE_N] & ~flash_ctl[CTL_OE_N] &
                       flash_ctl[CTL_WE_N] & flash_ctl[CTL_RP_N];
   assign flash_data = w_drive ? w_busWord : 16'hzzzz;

   assign busy_o = ~r_sr[SR_READY];
   assign sr_o   = r_sr;

endmodule

// File: tb/tb_flash_responder.sv
// Scoreboard bench for flash_responder: reads push expected words from a
// shadow array into a queue and pop them when the bus data is sampled.
module tb_flash_responder;

   localparam int PROG_CYC   = 8;
   localparam int ERASE_CYC  = 16;
   localparam int BLOCK_LOG2 = 6;
   localparam int ERASE_BUSY = (1 << BLOCK_LOG2) + ERASE_CYC;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [22:0] flash_addr = 23'h0;
   logic [7:0]  flash_ctl = 8'h3F;
   logic [15:0] tbData = 16'h0;
   logic        tbDrive = 1'b0;
   logic        tbVpen = 1'b1;
   logic        tbRpN = 1'b1;
   logic        tbByteN = 1'b1;
   wire  [15:0] flash_data;
   logic        busy_o;
   logic [7:0]  sr_o;

   int          checkCount = 0;
   int          errorCount = 0;
   int          cyc;
   logic [15:0] model [0:1023];
   logic [15:0] expQ [$];
   string       tagQ [$];

   assign flash_data = tbDrive ? tbData : 16'hzzzz;

   always #5 clk = ~clk;

   flash_responder #(
      .ADDR_W(10), .BLOCK_LOG2(BLOCK_LOG2), .PROG_CYC(PROG_CYC), .ERASE_CYC(ERASE_CYC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .flash_addr (flash_addr),
      .flash_data (flash_data),
      .flash_ctl  (flash_ctl),
      .busy_o     (busy_o),
      .sr_o       (sr_o)
   );

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic weN, input logic oeN, input logic ceN,
                                input logic [22:0] addr, input logic [15:0] data, input logic drive);
      @(posedge clk);
      #1;
      flash_ctl  = {2'b00, tbByteN, tbVpen, tbRpN, ceN, oeN, weN};
      flash_addr = addr;
      tbData     = data;
      tbDrive    = drive;
   endtask

   task automatic busIdle();
      applyStimulus(1'b1, 1'b1, 1'b1, flash_addr, 16'h0000, 1'b0);
   endtask

   // Write cycle, commit cycle (we_n rising), then one idle cycle.
   task automatic busWrite(input logic [22:0] addr, input logic [15:0] data);
      applyStimulus(1'b0, 1'b1, 1'b0, addr, data, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, addr, data, 1'b0);
      busIdle();
   endtask

   task automatic readWords(input int first, input int n);
      for (int i = 0; i <= n; i++) begin
         if (i < n) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 23'((first + i) * 2), 16'h0000, 1'b0);
            expQ.push_back(model[first + i]);
            tagQ.push_back($sformatf("rd[%0h]", first + i));
         end else begin
            applyStimulus(1'b1, 1'b0, 1'b0, flash_addr, 16'h0000, 1'b0);
         end
         if (i > 0) begin
            @(negedge clk);
            checkOutput(tagQ.pop_front(), flash_data, expQ.pop_front());
         end
      end
      busIdle();
   endtask

   task automatic readOne(input logic [22:0] addr, input logic byteN, input logic [15:0] expected, input string tag);
      tbByteN = byteN;
      expQ.push_back(expected);
      tagQ.push_back(tag);
      applyStimulus(1'b1, 1'b0, 1'b0, addr, 16'h0000, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, addr, 16'h0000, 1'b0);
      @(negedge clk);
      checkOutput(tagQ.pop_front(), flash_data, expQ.pop_front());
      tbByteN = 1'b1;
      busIdle();
   endtask

   task automatic waitReady(output int cycles);
      cycles = 0;
      repeat (2000) begin
         @(negedge clk);
         if (!busy_o) break;
         cycles++;
      end
   endtask

   task automatic checkSr(input string tag, input logic [7:0] expected);
      @(negedge clk);
      checkOutput(tag, {8'h00, sr_o}, {8'h00, expected});
   endtask

   task automatic programWord(input int idx, input logic [15:0] data);
      int c;
      busWrite(23'h0, 16'h0040);
      busWrite(23'(idx * 2), data);
      waitReady(c);
      checkOutput($sformatf("progBusy[%0h]", idx), 16'(c), 16'(PROG_CYC));
      model[idx] = model[idx] & data;
      busWrite(23'h0, 16'h00FF);
   endtask

   task automatic eraseBlock(input logic [22:0] addr);
      int c;
      int base;
      busWrite(23'h0, 16'h0020);
      busWrite(addr, 16'h00D0);
      waitReady(c);
      checkOutput("eraseBusy", 16'(c), 16'(ERASE_BUSY));
      base = (int'(addr) >> 1) & ~((1 << BLOCK_LOG2) - 1);
      for (int i = 0; i < (1 << BLOCK_LOG2); i++) model[base + i] = 16'hFFFF;
      readOne(23'h0, 1'b1, 16'h0080, "srAfterErase");
      busWrite(23'h0, 16'h00FF);
   endtask

   initial begin
      #500000;
      errorCount++;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 1024; i++) model[i] = 16'hFFFF;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rstSr", {8'h00, sr_o}, 16'h0080);
      checkOutput("rstBusy", {15'h0, busy_o}, 16'h0000);
      @(posedge clk);
      #1 rst = 1'b1;

      readWords(0, 2);
      readWords(1023, 1);

      busWrite(23'h0, 16'h0040);
      busWrite(23'h0, 16'h1234);
      waitReady(cyc);
      checkOutput("progBusy[0]", 16'(cyc), 16'(PROG_CYC));
      model[0] = model[0] & 16'h1234;
      readOne(23'h0, 1'b1, 16'h0080, "srAfterProg");
      busWrite(23'h0, 16'h00FF);
      readWords(0, 1);
      readOne(23'h1, 1'b0, 16'h0012, "byteHi");
      readOne(23'h0, 1'b0, 16'h0034, "byteLo");

      programWord(0, 16'h00FF);
      readOne(23'h0, 1'b1, 16'h0034, "andSemantics");

      programWord(16'h3F, 16'h5A5A);
      programWord(16'h41, 16'h0F0F);
      readWords(16'h3F, 3);
      eraseBlock(23'h080);
      readWords(16'h3E, 4);
      readWords(16'h7E, 3);

      busWrite(23'h0, 16'h0020);
      busWrite(23'h0, 16'h0055);
      checkSr("eraseSeqErr", 8'hB0);
      busWrite(23'h0, 16'h0050);
      checkSr("clearStatus", 8'h80);
      tbVpen = 1'b0;
      busWrite(23'h0, 16'h0040);
      busWrite(23'(5 * 2), 16'h0000);
      checkSr("vpenLowProg", 8'h98);
      checkOutput("vpenLowBusy", {15'h0, busy_o}, 16'h0000);
      tbVpen = 1'b1;
      busWrite(23'h0, 16'h0050);
      busWrite(23'h0, 16'h00FF);
      readWords(5, 1);

`ifdef FLASH_RESP_ID_EN
      busWrite(23'h0, 16'h0090);
      readOne(23'h0, 1'b1, 16'h0089, "idMfr");
      readOne(23'h2, 1'b1, 16'h0018, "idDev");
      readOne(23'h4, 1'b1, 16'h0000, "idOther");
`else
      busWrite(23'h0, 16'h0090);
      checkSr("idDisabled", 8'hB0);
      busWrite(23'h0, 16'h0050);
`endif
      busWrite(23'h0, 16'h00FF);

      programWord(16'h85, 16'h1111);
      programWord(16'h93, 16'h7777);
      programWord(16'h94, 16'h4444);
      programWord(16'h99, 16'h2222);
      programWord(16'hBF, 16'h3333);
      busWrite(23'h0, 16'h0020);
      busWrite(23'h100, 16'h00D0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 0 || i == 19) checkOutput($sformatf("abortBusy%0d", i), {15'h0, busy_o}, 16'h0001);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      checkOutput("abortBusyLow", {15'h0, busy_o}, 16'h0000);
      checkOutput("abortSr", {8'h00, sr_o}, 16'h0080);
      for (int i = 0; i < 20; i++) model[16'h80 + i] = 16'hFFFF;
      readWords(16'h80, 1);
      readWords(16'h85, 1);
      readWords(16'h92, 4);
      readWords(16'h99, 1);
      readWords(16'hBF, 1);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
